// File: rtl/hack_screen_fetcher.sv
// Pixel source for the 640x480 path: double-buffers Hack screen words fetched from VRAM
// and serialises them one pixel per clk, with syncs delayed to match the pixel latency.
module hack_screen_fetcher #(
   parameter int unsigned H_START       = 64,
   parameter int unsigned V_START       = 112,
   parameter int unsigned PREFETCH_CLKS = 16,
   parameter logic        BORDER_PIXEL  = 1'b1,
   parameter logic [14:0] SCREEN_BASE   = 15'h4000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [9:0]  hpos,
   input  logic [9:0]  vpos,
   input  logic        active_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [14:0] vram_addr,
   output logic        vram_rd,
   input  logic [15:0] vram_data,
   input  logic        vram_valid,
   output logic        rgb,
   output logic        hsync,
   output logic        vsync,
   output logic        underrun
);

   localparam logic [9:0] H_ST  = 10'(H_START);
   localparam logic [9:0] H_END = 10'(H_START + 512);
   localparam logic [9:0] H_PF  = 10'(H_START - PREFETCH_CLKS);
   localparam logic [9:0] V_ST  = 10'(V_START);
   localparam logic [9:0] V_END = 10'(V_START + 256);

   typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;

   state_t      state_q, state_d;
   logic        rd_q, rd_d;
   logic [14:0] addr_q, addr_d;
   logic [5:0]  idx_q, idx_d;
   logic [7:0]  row_q, row_d;
   logic [15:0] next_q, next_d;
   logic [15:0] shift_q, shift_d;
   logic        disc_q, disc_d;
   logic        pend_q, pend_d;
   logic        underrun_q, underrun_d;
   logic        active_q, inwin_q, hsync_q, vsync_q;

   logic       h_win, v_win, in_win, boundary, underrun_ev;
   logic [3:0] col_lo;
   logic [7:0] row_now, start_row;

   function automatic logic [14:0] word_addr(input logic [7:0] row, input logic [4:0] idx);
      return SCREEN_BASE + {2'b00, row, idx};
   endfunction

   assign h_win       = (hpos >= H_ST) && (hpos < H_END);
   assign v_win       = (vpos >= V_ST) && (vpos < V_END);
   assign in_win      = h_win && v_win;
   assign col_lo      = hpos[3:0] - H_ST[3:0];
   assign row_now     = vpos[7:0] - V_ST[7:0];
   assign start_row   = pend_q ? row_q : row_now;
   assign boundary    = in_win && (col_lo == 4'd0);
   assign underrun_ev = boundary && (state_q != FULL);

   // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      addr_d     = addr_q;
      idx_d      = idx_q;
      row_d      = row_q;
      next_d     = next_q;
      shift_d    = shift_q;
      disc_d     = disc_q;
      pend_d     = pend_q;
      underrun_d = underrun_q | underrun_ev;

      if (boundary)
         shift_d = underrun_ev ? 16'h0000 : next_q;
      else if (in_win)
         shift_d = shift_q >> 1;

      unique case (state_q)
         IDLE: begin
            if ((hpos == H_PF && v_win) || pend_q) begin
               row_d   = start_row;
               idx_d   = 6'd0;
               rd_d    = 1'b1;
               addr_d  = word_addr(start_row, 5'd0);
               pend_d  = 1'b0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (vram_valid) begin
               // A word that already missed its slot is replaced by white.
               next_d  = disc_q ? 16'h0000 : vram_data;
               disc_d  = 1'b0;
               rd_d    = 1'b0;
               idx_d   = idx_q + 6'd1;
               state_d = FULL;
            end else if (underrun_ev) begin
               disc_d  = 1'b1;
            end
         end
         FULL: begin
            if (boundary) begin
               if (!idx_q[5]) begin
                  rd_d    = 1'b1;
                  addr_d  = word_addr(row_q, idx_q[4:0]);
                  state_d = FETCH;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DRAIN: begin
            if (hpos == H_PF && v_win) begin
               pend_d = 1'b1;
               row_d  = row_now;
            end
            if (vram_valid) begin
               rd_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // End of the window line: abandon buffering, but an unanswered request must be drained.
      if (hpos == H_END && (state_q == FETCH || state_q == FULL)) begin
         disc_d = 1'b0;
         if (state_q == FETCH && !vram_valid) begin
            state_d = DRAIN;
         end else begin
            rd_d    = 1'b0;
            state_d = IDLE;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rd_q       <= 1'b0;
         addr_q     <= SCREEN_BASE;
         idx_q      <= 6'd0;
         row_q      <= 8'd0;
         next_q     <= 16'h0000;
         shift_q    <= 16'h0000;
         disc_q     <= 1'b0;
         pend_q     <= 1'b0;
         underrun_q <= 1'b0;
         active_q   <= 1'b0;
         inwin_q    <= 1'b0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         addr_q     <= addr_d;
         idx_q      <= idx_d;
         row_q      <= row_d;
         next_q     <= next_d;
         shift_q    <= shift_d;
         disc_q     <= disc_d;
         pend_q     <= pend_d;
         underrun_q <= underrun_d;
         active_q   <= active_in;
         inwin_q    <= in_win;
         hsync_q    <= hsync_in;
         vsync_q    <= vsync_in;
      end
   end

   assign vram_addr = addr_q;
   assign vram_rd   = rd_q;
   assign underrun  = underrun_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign rgb       = active_q ? (inwin_q ? ~shift_q[0] : BORDER_PIXEL) : 1'b0;

endmodule

// File: tb/tb_hack_screen_fetcher.sv
// Bench for hack_screen_fetcher: drives 640x480 timing line by line, answers VRAM reads
// from a random memory image and compares every pixel against a frame-level picture model.
module tb_hack_screen_fetcher;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  hpos, vpos;
   logic        active_in, hsync_in, vsync_in;

   logic [14:0] addr0, addr1;
   logic        rd0, rd1, valid0, valid1;
   logic [15:0] data0, data1;
   logic        rgb0, hs0, vs0, ur0;
   logic        rgb1, hs1, vs1, ur1;

   int total = 0;
   int bad   = 0;
   int lat   = 2;
   logic [15:0] mem [32768];
   logic [14:0] q0 [$];
   logic [14:0] q1 [$];
   logic line_rgb [800];
   logic line_ur  [800];

   always #5 clk = ~clk;

   hack_screen_fetcher dut (
      .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
      .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .vram_addr(addr0), .vram_rd(rd0), .vram_data(data0), .vram_valid(valid0),
      .rgb(rgb0), .hsync(hs0), .vsync(vs0), .underrun(ur0)
   );

   hack_screen_fetcher #(.SCREEN_BASE(15'h7FF0)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
      .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .vram_addr(addr1), .vram_rd(rd1), .vram_data(data1), .vram_valid(valid1),
      .rgb(rgb1), .hsync(hs1), .vsync(vs1), .underrun(ur1)
   );

   // VRAM responders: answer each request 'lat' clocks after it appears and log its address.
   initial begin
      int cnt = 0;
      logic rd_prev = 1'b0;
      logic was_ack;
      valid0 = 1'b0;
      data0  = 16'h0000;
      forever begin
         @(negedge clk);
         was_ack = valid0;
         valid0  = 1'b0;
         if (rd0 && (!rd_prev || was_ack)) begin
            q0.push_back(addr0);
            cnt = 0;
         end
         if (rd0) begin
            cnt++;
            if (cnt >= lat) begin
               valid0 = 1'b1;
               data0  = mem[addr0];
            end
         end else begin
            cnt = 0;
         end
         rd_prev = rd0;
      end
   end

   initial begin
      int cnt = 0;
      logic rd_prev = 1'b0;
      logic was_ack;
      valid1 = 1'b0;
      data1  = 16'h0000;
      forever begin
         @(negedge clk);
         was_ack = valid1;
         valid1  = 1'b0;
         if (rd1 && (!rd_prev || was_ack)) begin
            q1.push_back(addr1);
            cnt = 0;
         end
         if (rd1) begin
            cnt++;
            if (cnt >= lat) begin
               valid1 = 1'b1;
               data1  = mem[addr1];
            end
         end else begin
            cnt = 0;
         end
         rd_prev = rd1;
      end
   end

   // Picture the screen should show at (h, v), from the frame geometry and the memory image.
   function automatic logic model_rgb(input int h, input int v, input bit white_win);
      int row, col, a;
      logic [15:0] w;
      if (!(h < 640 && v < 480)) return 1'b0;
      if (h < 64 || h >= 576 || v < 112 || v >= 368) return 1'b1;
      if (white_win) return 1'b1;
      row = v - 112;
      col = h - 64;
      a   = (16384 + row * 32 + col / 16) % 32768;
      w   = mem[a];
      return ~w[col % 16];
   endfunction

   task automatic drive_line(input int v, input int hcount, input bit white_win);
      logic exp_rgb, exp_hs, exp_vs;
      for (int h = 0; h < hcount; h++) begin
         hpos      = 10'(h);
         vpos      = 10'(v);
         active_in = (h < 640 && v < 480);
         hsync_in  = !(h >= 656 && h < 752);
         vsync_in  = !(v == 490 || v == 491);
         exp_rgb   = model_rgb(h, v, white_win);
         exp_hs    = hsync_in;
         exp_vs    = vsync_in;
         @(negedge clk);
         line_rgb[h] = rgb0;
         line_ur[h]  = ur0;
         total++;
         if (rgb0 !== exp_rgb) begin
            bad++;
            $display("FAIL pixel v=%0d h=%0d rgb got=%b want=%b", v, h, rgb0, exp_rgb);
         end
         total++;
         if ({hs0, vs0} !== {exp_hs, exp_vs}) begin
            bad++;
            $display("FAIL syncs v=%0d h=%0d hs/vs got=%b%b want=%b%b", v, h, hs0, vs0, exp_hs, exp_vs);
         end
      end
   endtask

   task automatic check_reqs(input string name, input int v, input int want_n);
      total++;
      if (q0.size() != want_n) begin
         bad++;
         $display("FAIL %s req_count got=%0d want=%0d", name, q0.size(), want_n);
      end else begin
         for (int i = 0; i < want_n; i++) begin
            total++;
            if (q0[i] !== 15'(16384 + (v - 112) * 32 + i)) begin
               bad++;
               $display("FAIL %s req_addr[%0d] got=%h want=%h", name, i, q0[i], 15'(16384 + (v - 112) * 32 + i));
            end
         end
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; hpos = 10'd70; vpos = 10'd120;
      active_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({rgb0, hs0, vs0, rd0, ur0} !== 5'b01100) begin
         bad++;
         $display("FAIL reset rgb/hs/vs/rd/ur got=%b want=01100", {rgb0, hs0, vs0, rd0, ur0});
      end
      total++;
      if (addr0 !== 15'h4000) begin
         bad++;
         $display("FAIL reset_addr got=%h want=4000", addr0);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_picture;
      lat = 2;
      q0.delete(); q1.delete();
      drive_line(112, 800, 1'b0);
      total++;
      if (line_rgb[64] !== 1'b0) begin bad++; $display("FAIL pic_h64 got=%b want=0", line_rgb[64]); end
      for (int h = 65; h <= 78; h++) begin
         total++;
         if (line_rgb[h] !== 1'b1) begin bad++; $display("FAIL pic_h%0d got=%b want=1", h, line_rgb[h]); end
      end
      total++;
      if (line_rgb[95] !== 1'b0) begin bad++; $display("FAIL pic_h95 got=%b want=0", line_rgb[95]); end
      check_reqs("line112", 112, 32);
      total++;
      if (q1.size() != 32) begin
         bad++;
         $display("FAIL wrap_count got=%0d want=32", q1.size());
      end else begin
         total++;
         if (q1[0] !== 15'h7FF0 || q1[15] !== 15'h7FFF || q1[16] !== 15'h0000 || q1[31] !== 15'h000F) begin
            bad++;
            $display("FAIL wrap_addr got=%h/%h/%h/%h want=7ff0/7fff/0000/000f", q1[0], q1[15], q1[16], q1[31]);
         end
      end
   endtask

   task automatic test_border_blank;
      drive_line(200, 800, 1'b0);
      total++;
      if (line_rgb[10] !== 1'b1) begin bad++; $display("FAIL border_h10 got=%b want=1", line_rgb[10]); end
      total++;
      if (line_rgb[700] !== 1'b0) begin bad++; $display("FAIL blank_h700 got=%b want=0", line_rgb[700]); end
   endtask

   task automatic test_fetch_count;
      q0.delete(); drive_line(367, 800, 1'b0); check_reqs("line367", 367, 32);
      q0.delete(); drive_line(368, 800, 1'b0); check_reqs("line368", 368, 0);
      q0.delete(); drive_line(111, 800, 1'b0); check_reqs("line111", 111, 0);
      q0.delete(); drive_line(490, 800, 1'b0); check_reqs("line490", 490, 0);
      total++;
      if (ur0 !== 1'b0) begin bad++; $display("FAIL no_underrun got=%b want=0", ur0); end
   endtask

   task automatic test_underrun;
      lat = 20;
      q0.delete();
      drive_line(112, 800, 1'b1);
      total++;
      if (line_ur[63] !== 1'b0) begin bad++; $display("FAIL ur_before got=%b want=0", line_ur[63]); end
      total++;
      if (line_ur[80] !== 1'b1) begin bad++; $display("FAIL ur_col16 got=%b want=1", line_ur[80]); end
      total++;
      if (rd0 !== 1'b0) begin bad++; $display("FAIL drain_done rd got=%b want=0", rd0); end
      lat = 2;
      q0.delete();
      drive_line(113, 800, 1'b0);
      check_reqs("after_drain", 113, 32);
      total++;
      if (ur0 !== 1'b1) begin bad++; $display("FAIL ur_sticky got=%b want=1", ur0); end
   endtask

   task automatic test_reset_mid_line;
      lat = 2;
      drive_line(114, 50, 1'b0);
      total++;
      if (rd0 !== 1'b1) begin bad++; $display("FAIL mid_rd_before got=%b want=1", rd0); end
      reset_n = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      @(negedge clk);
      total++;
      if ({rd0, rgb0, ur0, hs0, vs0} !== 5'b00011) begin
         bad++;
         $display("FAIL mid_reset rd/rgb/ur/hs/vs got=%b want=00011", {rd0, rgb0, ur0, hs0, vs0});
      end
      reset_n = 1'b1;
      q0.delete();
      drive_line(115, 800, 1'b0);
      check_reqs("after_reset", 115, 32);
      total++;
      if (ur0 !== 1'b0) begin bad++; $display("FAIL ur_after_reset got=%b want=0", ur0); end
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
      mem[16'h4000] = 16'h0001;
      mem[16'h4001] = 16'h8000;
      @(negedge clk);
      test_reset;
      test_picture;
      test_border_blank;
      test_fetch_count;
      test_underrun;
      test_reset_mid_line;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
